player_motion_ctl: RTL and testbench



---
 rtl/player_motion_ctl_if.sv | 24 ++
 rtl/player_motion_ctl.sv | 141 ++++++++++++++
 tb/tb_player_motion_ctl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/player_motion_ctl_if.sv
// Control/status bundle between the button/vblank logic and the player motion controller.
// The master drives frame timing and buttons; the slave returns the sprite position and flags.
interface player_motion_ctl_if;
    logic        frame_tick;
    logic        enable;
    logic        btn_left;
    logic        btn_right;
    logic        btn_jump;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        airborne;
    logic        landed;
    logic        facing_left;

    modport master (
        output frame_tick, enable, btn_left, btn_right, btn_jump,
        input  xpos, ypos, airborne, landed, facing_left
    );

    modport slave (
        input  frame_tick, enable, btn_left, btn_right, btn_jump,
        output xpos, ypos, airborne, landed, facing_left
    );
endinterface

// File: rtl/player_motion_ctl.sv
// Per-frame player sprite motion: horizontal stepping plus a jump/gravity state machine.
// Position only changes on an enabled frame tick, so the sprite never moves mid-frame.
module player_motion_ctl #(
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 600,
    parameter int SPRITE_W = 48,
    parameter int SPRITE_H = 64,
    parameter int X_START  = 376,
    parameter int X_STEP   = 4,
    parameter int JUMP_V0  = 16,
    parameter int GRAVITY  = 1,
    parameter int V_MAX    = 16
) (
    input  logic               pclk,
    input  logic               rst,
    player_motion_ctl_if.slave motion
);
    localparam int GROUND_Y = SCREEN_H - SPRITE_H;
    localparam int X_MAX    = SCREEN_W - SPRITE_W;

    typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;

    state_t      state;
    logic [1:0]  left_sync;
    logic [1:0]  right_sync;
    logic [1:0]  jump_sync;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [5:0]  vy;
    logic        landed;
    logic        facing_left;

    logic        left;
    logic        right;
    logic        jump;
    logic        tick;
    logic [12:0] x_ext;
    logic [12:0] y_ext;
    logic [12:0] vy_ext;
    logic [12:0] x_right;
    logic [12:0] v_sum;
    logic [12:0] v_next;
    logic [12:0] y_fall;

    // Buttons are asynchronous to pclk; only the second flop feeds control logic.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            left_sync  <= 2'b00;
            right_sync <= 2'b00;
            jump_sync  <= 2'b00;
        end else begin
            left_sync  <= {left_sync[0],  motion.btn_left};
            right_sync <= {right_sync[0], motion.btn_right};
            jump_sync  <= {jump_sync[0],  motion.btn_jump};
        end
    end

    assign left  = left_sync[1];
    assign right = right_sync[1];
    assign jump  = jump_sync[1];
    assign tick  = motion.frame_tick & motion.enable;

    // 13-bit intermediates keep the comparisons free of wraparound.
    assign x_ext   = {1'b0, xpos};
    assign y_ext   = {1'b0, ypos};
    assign vy_ext  = {7'd0, vy};
    assign x_right = x_ext + 13'(X_STEP);
    assign v_sum   = vy_ext + 13'(GRAVITY);
    assign v_next  = (v_sum > 13'(V_MAX)) ? 13'(V_MAX) : v_sum;
    assign y_fall  = y_ext + v_next;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            xpos        <= 12'(X_START);
            ypos        <= 12'(GROUND_Y);
            vy          <= 6'd0;
            landed      <= 1'b0;
            facing_left <= 1'b0;
        end else begin
            landed <= 1'b0;
            if (tick) begin
                if (left && !right) begin
                    facing_left <= 1'b1;
                    if (x_ext < 13'(X_STEP))
                        xpos <= 12'd0;
                    else
                        xpos <= xpos - 12'(X_STEP);
                end else if (right && !left) begin
                    facing_left <= 1'b0;
                    if (x_right > 13'(X_MAX))
                        xpos <= 12'(X_MAX);
                    else
                        xpos <= x_right[11:0];
                end

                case (state)
                    IDLE: begin
                        if (jump) begin
                            state <= RISE;
                            vy    <= 6'(JUMP_V0);
                        end
                    end
                    RISE: begin
                        if (y_ext < vy_ext) begin
                            ypos  <= 12'd0;
                            vy    <= 6'd0;
                            state <= FALL;
                        end else begin
                            ypos <= ypos - {6'd0, vy};
                            if (vy_ext <= 13'(GRAVITY)) begin
                                vy    <= 6'd0;
                                state <= FALL;
                            end else begin
                                vy <= vy - 6'(GRAVITY);
                            end
                        end
                    end
                    FALL: begin
                        if (y_fall >= 13'(GROUND_Y)) begin
                            ypos   <= 12'(GROUND_Y);
                            vy     <= 6'd0;
                            state  <= IDLE;
                            landed <= 1'b1;
                        end else begin
                            ypos <= y_fall[11:0];
                            vy   <= v_next[5:0];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign motion.xpos        = xpos;
    assign motion.ypos        = ypos;
    assign motion.airborne    = (state != IDLE);
    assign motion.landed      = landed;
    assign motion.facing_left = facing_left;
endmodule

// File: tb/tb_player_motion_ctl.sv
// Directed bench for player_motion_ctl: horizontal saturation, jump arc, auto-hop, pause and reset.
// Expected trajectories are hand-computed constants for the default parameters.
module tb_player_motion_ctl;
    logic pclk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;

    // ypos after each tick following the launch tick: 16 rising ticks, then 16 falling ticks.
    int yTraj [32] = '{520, 505, 491, 478, 466, 455, 445, 436,
                       428, 421, 415, 410, 406, 403, 401, 400,
                       401, 403, 406, 410, 415, 421, 428, 436,
                       445, 455, 466, 478, 491, 505, 520, 536};

    player_motion_ctl_if motion();

    player_motion_ctl dut (
        .pclk   (pclk),
        .rst    (rst),
        .motion (motion)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic left, input logic right, input logic jump, input logic en);
        @(negedge pclk);
        motion.btn_left  = left;
        motion.btn_right = right;
        motion.btn_jump  = jump;
        motion.enable    = en;
        repeat (3) @(negedge pclk);
    endtask

    task automatic frameTick();
        @(negedge pclk);
        motion.frame_tick = 1'b1;
        @(negedge pclk);
        motion.frame_tick = 1'b0;
    endtask

    task automatic checkArc(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            frameTick();
            checkOutput($sformatf("arc_y[%0d]", i), 32'(motion.ypos), 32'(yTraj[i]));
            checkOutput($sformatf("arc_air[%0d]", i), 32'(motion.airborne), 32'(i < 31));
            checkOutput($sformatf("arc_landed[%0d]", i), 32'(motion.landed), 32'(i == 31));
        end
    endtask

    initial begin
        rst               = 1'b1;
        motion.frame_tick = 1'b0;
        motion.enable     = 1'b1;
        motion.btn_left   = 1'b0;
        motion.btn_right  = 1'b0;
        motion.btn_jump   = 1'b0;
        repeat (2) @(negedge pclk);
        checkOutput("reset_x", 32'(motion.xpos), 32'd376);
        checkOutput("reset_y", 32'(motion.ypos), 32'd536);
        checkOutput("reset_air", 32'(motion.airborne), 32'd0);
        checkOutput("reset_landed", 32'(motion.landed), 32'd0);
        checkOutput("reset_facing", 32'(motion.facing_left), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            frameTick();
            checkOutput("idle_x", 32'(motion.xpos), 32'd376);
            checkOutput("idle_y", 32'(motion.ypos), 32'd536);
            checkOutput("idle_air", 32'(motion.airborne), 32'd0);
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 200; k++) begin
            frameTick();
            checkOutput("left_x", 32'(motion.xpos), (376 - 4 * k > 0) ? 32'(376 - 4 * k) : 32'd0);
        end
        checkOutput("left_facing", 32'(motion.facing_left), 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 200; k++) begin
            frameTick();
            checkOutput("right_x", 32'(motion.xpos), (4 * k < 752) ? 32'(4 * k) : 32'd752);
        end
        checkOutput("right_facing", 32'(motion.facing_left), 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            frameTick();
            checkOutput("both_x", 32'(motion.xpos), 32'd752);
        end
        checkOutput("both_facing", 32'(motion.facing_left), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (94) frameTick();
        checkOutput("recenter_x", 32'(motion.xpos), 32'd376);
        checkOutput("recenter_facing", 32'(motion.facing_left), 32'd1);

        // Single jump: button released right after the launch tick.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        frameTick();
        checkOutput("launch_air", 32'(motion.airborne), 32'd1);
        checkOutput("launch_y", 32'(motion.ypos), 32'd536);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkArc(0, 31);
        @(negedge pclk);
        checkOutput("landed_one_cycle", 32'(motion.landed), 32'd0);
        frameTick();
        checkOutput("no_rejump_air", 32'(motion.airborne), 32'd0);

        // Held jump: each landing is followed by a relaunch on the next tick.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int hop = 0; hop < 2; hop++) begin
            frameTick();
            checkOutput("hop_launch_air", 32'(motion.airborne), 32'd1);
            checkOutput("hop_launch_y", 32'(motion.ypos), 32'd536);
            checkOutput("hop_launch_landed", 32'(motion.landed), 32'd0);
            checkArc(0, 31);
        end

        frameTick();
        checkOutput("hop3_launch_air", 32'(motion.airborne), 32'd1);
        checkArc(0, 15);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkArc(16, 20);

        // Paused mid-fall with left held: nothing may move.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            frameTick();
            checkOutput("pause_y", 32'(motion.ypos), 32'd415);
            checkOutput("pause_x", 32'(motion.xpos), 32'd376);
            checkOutput("pause_air", 32'(motion.airborne), 32'd1);
        end
        checkOutput("pause_facing", 32'(motion.facing_left), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkArc(21, 31);

        // No frame tick: button activity must not move anything.
        for (int k = 0; k < 24; k++) begin
            @(negedge pclk);
            motion.btn_left  = k[0];
            motion.btn_right = k[1];
            motion.btn_jump  = k[2];
        end
        repeat (3) @(negedge pclk);
        checkOutput("notick_x", 32'(motion.xpos), 32'd376);
        checkOutput("notick_y", 32'(motion.ypos), 32'd536);
        checkOutput("notick_air", 32'(motion.airborne), 32'd0);

        // Reset mid-rise with the sprite moved right.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        frameTick();
        checkOutput("rr_x0", 32'(motion.xpos), 32'd380);
        checkOutput("rr_y0", 32'(motion.ypos), 32'd536);
        frameTick();
        checkOutput("rr_x1", 32'(motion.xpos), 32'd384);
        checkOutput("rr_y1", 32'(motion.ypos), 32'd520);
        frameTick();
        checkOutput("rr_x2", 32'(motion.xpos), 32'd388);
        checkOutput("rr_y2", 32'(motion.ypos), 32'd505);
        checkOutput("rr_air", 32'(motion.airborne), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_x", 32'(motion.xpos), 32'd376);
        checkOutput("async_rst_y", 32'(motion.ypos), 32'd536);
        checkOutput("async_rst_air", 32'(motion.airborne), 32'd0);
        checkOutput("async_rst_facing", 32'(motion.facing_left), 32'd0);
        checkOutput("async_rst_landed", 32'(motion.landed), 32'd0);
        @(negedge pclk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
